// File: rtl/rv32m_muldiv_if.sv
// Request/response bundle of the RV32M multiply/divide unit.
// master drives the request side (decode flags, operands, START); slave is the unit.
interface rv32m_muldiv_if;
   logic        START;
   logic        INST_MUL;
   logic        INST_MULH;
   logic        INST_MULHSU;
   logic        INST_MULHU;
   logic        INST_DIV;
   logic        INST_DIVU;
   logic        INST_REM;
   logic        INST_REMU;
   logic [31:0] RS1;
   logic [31:0] RS2;
   logic        BUSY;
   logic        READY;
   logic [31:0] RD_DATA;

   modport master (
      output START, INST_MUL, INST_MULH, INST_MULHSU, INST_MULHU,
             INST_DIV, INST_DIVU, INST_REM, INST_REMU, RS1, RS2,
      input  BUSY, READY, RD_DATA
   );

   modport slave (
      input  START, INST_MUL, INST_MULH, INST_MULHSU, INST_MULHU,
             INST_DIV, INST_DIVU, INST_REM, INST_REMU, RS1, RS2,
      output BUSY, READY, RD_DATA
   );
endinterface

// File: rtl/rv32m_muldiv.sv
// RV32M multiply/divide unit: restoring divider plus shift-add or single-cycle multiplier.
// Build option: define RV32M_FAST_MUL_EN for the single-cycle 64-bit multiply path.
module rv32m_muldiv (
   input  logic          CLK,
   input  logic          RST_N,
   rv32m_muldiv_if.slave bus
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
   typedef enum logic [2:0] {
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
   } op_e;

   state_e      state_reg, state_next;
   op_e         op_reg, op_next;
   logic [31:0] opnd_reg, opnd_next;
   logic [63:0] acc_reg, acc_next;
   logic [5:0]  cnt_reg, cnt_next;
   logic        neg_q_reg, neg_q_next;
   logic        neg_r_reg, neg_r_next;
   logic [31:0] rd_data_reg, rd_data_next;

   // Request decode
   op_e         op_sel;
   logic        any_flag;
   logic        a_signed, b_signed;
   logic        sel_div, sel_rem;
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   logic        div_zero, div_ovf;

   always_comb begin
      any_flag = bus.INST_MUL | bus.INST_MULH | bus.INST_MULHSU | bus.INST_MULHU |
                 bus.INST_DIV | bus.INST_DIVU | bus.INST_REM    | bus.INST_REMU;
      op_sel = OP_MUL;
      if (bus.INST_MUL)         op_sel = OP_MUL;
      else if (bus.INST_MULH)   op_sel = OP_MULH;
      else if (bus.INST_MULHSU) op_sel = OP_MULHSU;
      else if (bus.INST_MULHU)  op_sel = OP_MULHU;
      else if (bus.INST_DIV)    op_sel = OP_DIV;
      else if (bus.INST_DIVU)   op_sel = OP_DIVU;
      else if (bus.INST_REM)    op_sel = OP_REM;
      else if (bus.INST_REMU)   op_sel = OP_REMU;

      a_signed = op_sel inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
      b_signed = op_sel inside {OP_MULH, OP_DIV, OP_REM};
      sel_div  = op_sel inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
      sel_rem  = op_sel inside {OP_REM, OP_REMU};
      a_neg    = a_signed & bus.RS1[31];
      b_neg    = b_signed & bus.RS2[31];
      a_mag    = a_neg ? -bus.RS1 : bus.RS1;
      b_mag    = b_neg ? -bus.RS2 : bus.RS2;
      div_zero = (bus.RS2 == 32'd0);
      div_ovf  = (op_sel inside {OP_DIV, OP_REM}) &&
                 (bus.RS1 == 32'h8000_0000) && (bus.RS2 == 32'hFFFF_FFFF);
   end

   // Restoring division step: acc holds {remainder, dividend/quotient}, opnd the divisor.
   // The partial remainder stays below the divisor, so bit 32 of the difference is the borrow.
   logic [32:0] rem_shift, div_diff;
   logic        div_ge;
   logic [63:0] div_step;
   logic [31:0] q_fix, r_fix;

   always_comb begin
      rem_shift = {acc_reg[63:32], acc_reg[31]};
      div_diff  = rem_shift - {1'b0, opnd_reg};
      div_ge    = ~div_diff[32];
      div_step  = div_ge ? {div_diff[31:0],  acc_reg[30:0], 1'b1}
                         : {rem_shift[31:0], acc_reg[30:0], 1'b0};
      q_fix     = neg_q_reg ? -div_step[31:0]  : div_step[31:0];
      r_fix     = neg_r_reg ? -div_step[63:32] : div_step[63:32];
   end

`ifdef RV32M_FAST_MUL_EN
   // Sign-extended 64x64 multiply keeps the low 64 bits of the 33x33 signed product.
   logic [63:0] fast_a, fast_b, fast_prod;

   always_comb begin
      fast_a    = {{32{a_neg}}, bus.RS1};
      fast_b    = {{32{b_neg}}, bus.RS2};
      fast_prod = fast_a * fast_b;
   end
`else
   // Shift-add step: acc holds {partial product, multiplier}, opnd the multiplicand.
   logic [32:0] mul_sum;
   logic [63:0] mul_step, mul_fix;

   always_comb begin
      mul_sum  = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opnd_reg} : 33'd0);
      mul_step = {mul_sum, acc_reg[31:1]};
      mul_fix  = neg_q_reg ? -mul_step : mul_step;
   end
`endif

   always_comb begin
      state_next   = state_reg;
      op_next      = op_reg;
      opnd_next    = opnd_reg;
      acc_next     = acc_reg;
      cnt_next     = cnt_reg;
      neg_q_next   = neg_q_reg;
      neg_r_next   = neg_r_reg;
      rd_data_next = rd_data_reg;

      case (state_reg)
         IDLE: begin
            if (bus.START && any_flag) begin
               op_next    = op_sel;
               neg_q_next = a_neg ^ b_neg;
               neg_r_next = a_neg;
               cnt_next   = 6'd0;
               if (sel_div) begin
                  if (div_zero) begin
                     rd_data_next = sel_rem ? bus.RS1 : 32'hFFFF_FFFF;
                     state_next   = DONE;
                  end else if (div_ovf) begin
                     rd_data_next = sel_rem ? 32'd0 : 32'h8000_0000;
                     state_next   = DONE;
                  end else begin
                     opnd_next  = b_mag;
                     acc_next   = {32'd0, a_mag};
                     state_next = DIV;
                  end
               end else begin
`ifdef RV32M_FAST_MUL_EN
                  rd_data_next = (op_sel == OP_MUL) ? fast_prod[31:0] : fast_prod[63:32];
                  state_next   = DONE;
`else
                  opnd_next  = a_mag;
                  acc_next   = {32'd0, b_mag};
                  state_next = MUL;
`endif
               end
            end
         end
`ifndef RV32M_FAST_MUL_EN
         MUL: begin
            acc_next = mul_step;
            cnt_next = cnt_reg + 6'd1;
            if (cnt_reg == 6'd31) begin
               rd_data_next = (op_reg == OP_MUL) ? mul_fix[31:0] : mul_fix[63:32];
               state_next   = DONE;
            end
         end
`endif
         DIV: begin
            acc_next = div_step;
            cnt_next = cnt_reg + 6'd1;
            if (cnt_reg == 6'd31) begin
               rd_data_next = (op_reg inside {OP_REM, OP_REMU}) ? r_fix : q_fix;
               state_next   = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_reg   <= IDLE;
         op_reg      <= OP_MUL;
         opnd_reg    <= 32'd0;
         acc_reg     <= 64'd0;
         cnt_reg     <= 6'd0;
         neg_q_reg   <= 1'b0;
         neg_r_reg   <= 1'b0;
         rd_data_reg <= 32'd0;
      end else begin
         state_reg   <= state_next;
         op_reg      <= op_next;
         opnd_reg    <= opnd_next;
         acc_reg     <= acc_next;
         cnt_reg     <= cnt_next;
         neg_q_reg   <= neg_q_next;
         neg_r_reg   <= neg_r_next;
         rd_data_reg <= rd_data_next;
      end
   end

   assign bus.BUSY    = (state_reg != IDLE);
   assign bus.READY   = (state_reg == DONE);
   assign bus.RD_DATA = rd_data_reg;

endmodule
